cpu_axi_arbiter: RTL and testbench

Shares the core's single AXI master port between the instruction-fetch read client (`i_*`) and the data-memory client (`d_*`, cached and uncached traffic already merged upstream). Reads are arbitrated per burst with data-side priority and a starvation guard for fetch. Writes come only from the data side and pass straight through. A write-pending tracker keeps data reads behind outstanding data writes, so uncached store→load to device registers stays ordered. Sits between the two cache/arbitration front-ends and the SoC AXI interconnect.

---
 rtl/cpu_axi_pkg.sv | 21 ++
 rtl/cpu_axi_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_cpu_axi_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_axi_pkg.sv
// rtl/cpu_axi_pkg.sv - shared types and AXI constants for the CPU AXI arbiter
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

endpackage

// File: rtl/cpu_axi_arbiter.sv
// rtl/cpu_axi_arbiter.sv - shares one AXI master between fetch reads and data reads/writes
module cpu_axi_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch read client
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  // data read client
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  // data write client
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  // master read channels
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [3:0]  m_arid,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  // master write channels
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [3:0]  m_awid,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  output logic        m_bready
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  rd_state_e         state_q;
  logic              owner_q;       // 1 = data client owns the current burst
  logic [31:0]       araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [3:0]        arid_q;
  logic [CNT_W-1:0]  starve_q;
  logic              wr_pending_q;
  logic              wr_pending_d;

  logic              i_elig;
  logic              d_elig;
  logic              grant_i;
  logic              grant_d;
  logic              rd_active;

  // Data wins unless fetch is waiting and has already been passed over STARVE_MAX times.
  function automatic logic pick_data(input logic ie, input logic de, input logic [CNT_W-1:0] cnt);
    return de && !(ie && (cnt == STARVE_LIM));
  endfunction

  // Eligibility and single-cycle grant decision while idle.
  always_comb begin
    i_elig  = i_arvalid;
    d_elig  = d_arvalid && !wr_pending_q && !d_awvalid;
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == R_IDLE && rst) begin
      grant_d = pick_data(i_elig, d_elig, starve_q);
      grant_i = i_elig && !grant_d;
    end
  end

  assign i_arready = grant_i;
  assign d_arready = grant_d;

  // Read FSM: latch the winner's AR fields, issue AR, then route R beats to the owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= R_IDLE;
      owner_q  <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
      arid_q   <= AXI_ID_INST;
      starve_q <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (grant_d) begin
            owner_q  <= 1'b1;
            araddr_q <= d_araddr;
            arlen_q  <= d_arlen;
            arsize_q <= d_arsize;
            arid_q   <= AXI_ID_DATA;
            state_q  <= R_ADDR;
            if (!i_elig) starve_q <= '0;
            else if (starve_q != STARVE_LIM) starve_q <= starve_q + 1'b1;
          end else if (grant_i) begin
            owner_q  <= 1'b0;
            araddr_q <= i_araddr;
            arlen_q  <= i_arlen;
            arsize_q <= i_arsize;
            arid_q   <= AXI_ID_INST;
            state_q  <= R_ADDR;
            starve_q <= '0;
          end
        end
        R_ADDR: if (m_arready) state_q <= R_DATA;
        R_DATA: if (m_rvalid && m_rready && m_rlast) state_q <= R_IDLE;
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign m_arvalid = (state_q == R_ADDR);
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = arsize_q;
  assign m_arid    = arid_q;

  // Route the R channel to the burst owner; the other client sees zeros.
  always_comb begin
    rd_active = (state_q == R_DATA);
    i_rvalid  = rd_active && !owner_q && m_rvalid;
    i_rlast   = rd_active && !owner_q && m_rlast;
    i_rdata   = (rd_active && !owner_q) ? m_rdata : '0;
    d_rvalid  = rd_active && owner_q && m_rvalid;
    d_rlast   = rd_active && owner_q && m_rlast;
    d_rdata   = (rd_active && owner_q) ? m_rdata : '0;
    m_rready  = rd_active && (owner_q ? d_rready : i_rready);
  end

  // Write channels pass straight through with no added latency.
  assign m_awaddr  = d_awaddr;
  assign m_awlen   = d_awlen;
  assign m_awsize  = d_awsize;
  assign m_awid    = AXI_ID_DATA;
  assign m_awvalid = d_awvalid;
  assign d_awready = m_awready;
  assign m_wdata   = d_wdata;
  assign m_wstrb   = d_wstrb;
  assign m_wlast   = d_wlast;
  assign m_wvalid  = d_wvalid;
  assign d_wready  = m_wready;
  assign d_bvalid  = m_bvalid;
  assign m_bready  = d_bready;

  // A new AW handshake outranks a B handshake in the same cycle.
  always_comb begin
    wr_pending_d = wr_pending_q;
    if (m_bvalid && m_bready) wr_pending_d = 1'b0;
    if (m_awvalid && m_awready) wr_pending_d = 1'b1;
  end

  // Outstanding-write flag that holds back data reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_pending_q <= 1'b0;
    else      wr_pending_q <= wr_pending_d;
  end

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// tb/tb_cpu_axi_arbiter.sv - self-checking bench for cpu_axi_arbiter
module tb_cpu_axi_arbiter;

  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata;
  logic [7:0]  i_arlen, d_arlen;
  logic [2:0]  i_arsize, d_arsize;
  logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
  logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic [31:0] d_awaddr, d_wdata;
  logic [7:0]  d_awlen;
  logic [2:0]  d_awsize;
  logic [3:0]  d_wstrb;
  logic        d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [3:0]  m_arid, m_awid, m_wstrb;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          streak;      // data grants in a row while fetch has been waiting
  int          wr_out;      // writes accepted on AW but not yet answered on B
  bit          i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic [7:0]  i_len, d_len;
  logic [2:0]  i_size, d_size;

  cpu_axi_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_bvalid(d_bvalid), .d_bready(d_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arid(m_arid),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awid(m_awid),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return a ^ (32'h9E37_79B9 * 32'(b + 1));
  endfunction

  task automatic init_inputs();
    i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arvalid = 0; i_rready = 0;
    d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 0; d_rready = 0;
    d_awaddr = '0; d_awlen = '0; d_awsize = '0; d_awvalid = 0;
    d_wdata = '0; d_wstrb = '0; d_wlast = 0; d_wvalid = 0; d_bready = 0;
    m_arready = 0; m_rdata = '0; m_rlast = 0; m_rvalid = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0;
  endtask

  // Address phase and beat routing for a burst the model says was just granted.
  task automatic run_read_burst(input bit is_data, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    int guard;
    int beat;
    bit done, mv, own_rdy;
    logic ov, ol, xv, xl;
    logic [31:0] od, xd;
    @(negedge clk);
    i_arvalid = i_req; d_arvalid = d_req;
    m_arready = 1'($urandom_range(0, 1));
    #1;
    checks++; if (m_arvalid !== 1'b1) begin failures++; $display("FAIL ar_valid_latency got=%b exp=1", m_arvalid); end
    checks++; if (m_arid !== (is_data ? 4'd1 : 4'd0)) begin failures++; $display("FAIL ar_id got=%0d exp=%0d", m_arid, is_data); end
    checks++; if (m_araddr !== addr) begin failures++; $display("FAIL ar_addr got=%h exp=%h", m_araddr, addr); end
    checks++; if (m_arlen !== len || m_arsize !== size) begin failures++; $display("FAIL ar_len_size got=%0d/%0d exp=%0d/%0d", m_arlen, m_arsize, len, size); end
    guard = 0;
    while (m_arready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      m_arready = (guard >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      checks++; if (m_arvalid !== 1'b1 || i_arready !== 1'b0 || d_arready !== 1'b0) begin failures++; $display("FAIL ar_hold got=%b%b%b exp=100", m_arvalid, i_arready, d_arready); end
      guard++;
    end
    beat = 0; guard = 0; done = 0;
    while (!done && guard < 400) begin
      @(negedge clk);
      m_arready = 0;
      mv = ($urandom_range(0, 2) != 0);
      own_rdy = ($urandom_range(0, 3) != 0);
      m_rvalid = mv; m_rdata = beat_data(addr, beat); m_rlast = (beat == int'(len));
      if (is_data) begin d_rready = own_rdy; i_rready = 1'($urandom_range(0, 1)); end
      else begin i_rready = own_rdy; d_rready = 1'($urandom_range(0, 1)); end
      #1;
      ov = is_data ? d_rvalid : i_rvalid; ol = is_data ? d_rlast : i_rlast; od = is_data ? d_rdata : i_rdata;
      xv = is_data ? i_rvalid : d_rvalid; xl = is_data ? i_rlast : d_rlast; xd = is_data ? i_rdata : d_rdata;
      checks++; if (m_rready !== own_rdy) begin failures++; $display("FAIL m_rready got=%b exp=%b", m_rready, own_rdy); end
      checks++; if (ov !== mv || ol !== m_rlast || od !== beat_data(addr, beat)) begin failures++; $display("FAIL owner_beat got=%b/%b/%h exp=%b/%b/%h", ov, ol, od, mv, m_rlast, beat_data(addr, beat)); end
      checks++; if (xv !== 1'b0 || xl !== 1'b0 || xd !== 32'h0) begin failures++; $display("FAIL other_client_r got=%b/%b/%h exp=0/0/0", xv, xl, xd); end
      checks++; if (m_arvalid !== 1'b0 || i_arready !== 1'b0 || d_arready !== 1'b0) begin failures++; $display("FAIL ar_quiet_in_data got=%b%b%b exp=000", m_arvalid, i_arready, d_arready); end
      if (mv && own_rdy) begin
        if (beat == int'(len)) done = 1;
        beat++;
      end
      guard++;
    end
    checks++; if (!done) begin failures++; $display("FAIL burst_timeout got=%0d beats exp=%0d", beat, int'(len) + 1); end
  endtask

  // One idle-state arbitration: compare grant against the model, then run the granted burst.
  task automatic grant_and_burst(output int who);
    bit ie, de, exp_d, exp_i;
    @(negedge clk);
    m_rvalid = 0; m_rlast = 0; m_rdata = '0; m_arready = 0; m_bvalid = 0; d_bready = 0;
    i_rready = 0; d_rready = 0;
    i_arvalid = i_req; i_araddr = i_addr; i_arlen = i_len; i_arsize = i_size;
    d_arvalid = d_req; d_araddr = d_addr; d_arlen = d_len; d_arsize = d_size;
    #1;
    ie = i_req;
    de = d_req && (wr_out == 0) && !d_awvalid;
    exp_d = de && !(ie && streak == STARVE_MAX);
    exp_i = ie && !exp_d;
    checks++; if (i_arready !== exp_i) begin failures++; $display("FAIL i_arready_grant got=%b exp=%b", i_arready, exp_i); end
    checks++; if (d_arready !== exp_d) begin failures++; $display("FAIL d_arready_grant got=%b exp=%b", d_arready, exp_d); end
    who = (d_arready === 1'b1) ? 1 : ((i_arready === 1'b1) ? 0 : -1);
    if (exp_d) begin
      streak = ie ? ((streak < STARVE_MAX) ? streak + 1 : STARVE_MAX) : 0;
      d_req = 0;
      run_read_burst(1'b1, d_addr, d_len, d_size);
    end else if (exp_i) begin
      streak = 0;
      i_req = 0;
      run_read_burst(1'b0, i_addr, i_len, i_size);
    end
  endtask

  task automatic test_reset();
    rst = 0;
    init_inputs();
    streak = 0; wr_out = 0; i_req = 0; d_req = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast} !== 6'b0) begin failures++; $display("FAIL reset_client_flags got=%b exp=0", {i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast}); end
    checks++; if (m_arvalid !== 1'b0 || m_rready !== 1'b0) begin failures++; $display("FAIL reset_master_flags got=%b%b exp=00", m_arvalid, m_rready); end
    checks++; if (m_araddr !== 32'h0 || m_arlen !== 8'h0 || m_arsize !== 3'h0 || m_arid !== 4'h0) begin failures++; $display("FAIL reset_ar_regs got=%h/%h/%h/%h exp=0", m_araddr, m_arlen, m_arsize, m_arid); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_fetch_only();
    int who;
    i_req = 1; i_addr = 32'hBFC0_0000; i_len = 8'd7; i_size = 3'd2;
    grant_and_burst(who);
    checks++; if (who !== 0) begin failures++; $display("FAIL fetch_only_winner got=%0d exp=0", who); end
    i_req = 1; i_addr = 32'hBFC0_0020; i_len = 8'd3; i_size = 3'd2;
    grant_and_burst(who);
    checks++; if (who !== 0) begin failures++; $display("FAIL fetch_back_to_back got=%0d exp=0", who); end
  endtask

  task automatic test_both_same_cycle();
    int who;
    i_req = 1; i_addr = 32'hBFC0_0100; i_len = 8'd3; i_size = 3'd2;
    d_req = 1; d_addr = 32'h8000_1000; d_len = 8'd1; d_size = 3'd2;
    grant_and_burst(who);
    checks++; if (who !== 1) begin failures++; $display("FAIL both_first got=%0d exp=1", who); end
    grant_and_burst(who);
    checks++; if (who !== 0) begin failures++; $display("FAIL both_second got=%0d exp=0", who); end
  endtask

  task automatic test_starvation();
    int who, exp_who;
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    streak = 0; wr_out = 0; i_req = 0; d_req = 0;
    for (int k = 0; k < 19; k++) begin
      if (!i_req && k < 18) begin i_req = 1; i_addr = 32'hBFC0_0000 + 32'(k * 64); i_len = 8'($urandom_range(0, 3)); i_size = 3'd2; end
      if (!d_req) begin d_req = 1; d_addr = 32'h8000_0000 + 32'(k * 16); d_len = 8'($urandom_range(0, 3)); d_size = 3'd2; end
      exp_who = (k == 8 || k == 17) ? 0 : 1;
      grant_and_burst(who);
      checks++; if (who !== exp_who) begin failures++; $display("FAIL starve_round_%0d got=%0d exp=%0d", k, who, exp_who); end
    end
    d_req = 0;
  endtask

  task automatic test_write_order();
    int who;
    d_req = 1; d_addr = 32'h1FAF_F000; d_len = 8'd0; d_size = 3'd2;
    @(negedge clk);
    d_awvalid = 1; d_awaddr = 32'h1FAF_F000; d_awlen = 8'd0; d_awsize = 3'd2; m_awready = 1;
    d_arvalid = 1; d_araddr = d_addr; d_arlen = d_len; d_arsize = d_size;
    #1;
    checks++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'h1FAF_F000 || m_awid !== 4'd1 || d_awready !== 1'b1) begin failures++; $display("FAIL aw_passthrough got=%b/%h/%0d/%b exp=1/1faff000/1/1", m_awvalid, m_awaddr, m_awid, d_awready); end
    checks++; if (d_arready !== 1'b0) begin failures++; $display("FAIL load_blocked_by_aw got=%b exp=0", d_arready); end
    wr_out++;
    @(negedge clk);
    d_awvalid = 0; m_awready = 0;
    d_wvalid = 1; d_wdata = $urandom; d_wstrb = 4'hF; d_wlast = 1; m_wready = 1;
    #1;
    checks++; if (m_wdata !== d_wdata || m_wvalid !== 1'b1 || m_wlast !== 1'b1 || m_wstrb !== 4'hF || d_wready !== 1'b1) begin failures++; $display("FAIL w_passthrough got=%h/%b/%b/%h/%b exp=%h/1/1/f/1", m_wdata, m_wvalid, m_wlast, m_wstrb, d_wready, d_wdata); end
    checks++; if (d_arready !== 1'b0) begin failures++; $display("FAIL load_blocked_w got=%b exp=0", d_arready); end
    @(negedge clk);
    d_wvalid = 0; d_wlast = 0; m_wready = 0;
    #1;
    checks++; if (d_arready !== 1'b0 || m_arvalid !== 1'b0) begin failures++; $display("FAIL load_blocked_idle got=%b%b exp=00", d_arready, m_arvalid); end
    i_req = 1; i_addr = 32'hBFC0_0200; i_len = 8'd2; i_size = 3'd2;
    grant_and_burst(who);
    checks++; if (who !== 0) begin failures++; $display("FAIL fetch_ignores_wr got=%0d exp=0", who); end
    @(negedge clk);
    m_rvalid = 0; m_rlast = 0; i_rready = 0; d_rready = 0; i_arvalid = 0;
    m_bvalid = 1; d_bready = 1;
    #1;
    checks++; if (d_bvalid !== 1'b1 || m_bready !== 1'b1) begin failures++; $display("FAIL b_passthrough got=%b%b exp=11", d_bvalid, m_bready); end
    checks++; if (d_arready !== 1'b0 || m_arvalid !== 1'b0) begin failures++; $display("FAIL load_blocked_b_cycle got=%b%b exp=00", d_arready, m_arvalid); end
    wr_out--;
    grant_and_burst(who);
    checks++; if (who !== 1) begin failures++; $display("FAIL load_after_b got=%0d exp=1", who); end
  endtask

  task automatic test_b_aw_same_cycle();
    int who;
    d_req = 1; d_addr = 32'h1FAF_F004; d_len = 8'd0; d_size = 3'd2;
    @(negedge clk);
    d_arvalid = 1; d_araddr = d_addr; d_arlen = d_len; d_arsize = d_size;
    d_awvalid = 1; d_awaddr = 32'h1FAF_F004; m_awready = 1;
    #1; wr_out++;
    @(negedge clk);
    d_awvalid = 0; m_awready = 0; d_wvalid = 1; d_wlast = 1; d_wdata = $urandom; m_wready = 1;
    @(negedge clk);
    d_wvalid = 0; d_wlast = 0; m_wready = 0;
    d_awvalid = 1; d_awaddr = 32'h1FAF_F008; m_awready = 1; m_bvalid = 1; d_bready = 1;
    #1;
    checks++; if (d_arready !== 1'b0 || m_awvalid !== 1'b1 || d_bvalid !== 1'b1) begin failures++; $display("FAIL aw_b_same_cycle got=%b%b%b exp=011", d_arready, m_awvalid, d_bvalid); end
    @(negedge clk);
    d_awvalid = 0; m_awready = 0; m_bvalid = 0; d_bready = 0;
    d_wvalid = 1; d_wlast = 1; m_wready = 1;
    #1;
    checks++; if (d_arready !== 1'b0) begin failures++; $display("FAIL pending_kept_after_overlap got=%b exp=0", d_arready); end
    @(negedge clk);
    d_wvalid = 0; d_wlast = 0; m_wready = 0;
    #1;
    checks++; if (d_arready !== 1'b0) begin failures++; $display("FAIL pending_kept_idle got=%b exp=0", d_arready); end
    @(negedge clk);
    m_bvalid = 1; d_bready = 1;
    #1;
    checks++; if (d_arready !== 1'b0) begin failures++; $display("FAIL pending_kept_b2 got=%b exp=0", d_arready); end
    wr_out--;
    grant_and_burst(who);
    checks++; if (who !== 1) begin failures++; $display("FAIL load_after_second_b got=%0d exp=1", who); end
  endtask

  task automatic test_random();
    int who;
    for (int r = 0; r < 30; r++) begin
      if (!i_req && $urandom_range(0, 1)) begin i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC; i_len = 8'($urandom_range(0, 7)); i_size = 3'($urandom_range(0, 2)); end
      if (!d_req && ($urandom_range(0, 2) != 0 || !i_req)) begin d_req = 1; d_addr = $urandom & 32'hFFFF_FFFC; d_len = 8'($urandom_range(0, 7)); d_size = 3'($urandom_range(0, 2)); end
      grant_and_burst(who);
    end
    for (int r = 0; r < 2 && (i_req || d_req); r++) grant_and_burst(who);
  endtask

  task automatic test_reset_mid_burst();
    int who;
    @(negedge clk);
    m_rvalid = 0; m_rlast = 0; i_rready = 0; d_rready = 0; d_arvalid = 0;
    i_arvalid = 1; i_araddr = 32'h8000_0100; i_arlen = 8'd3; i_arsize = 3'd2;
    #1;
    checks++; if (i_arready !== 1'b1) begin failures++; $display("FAIL mid_reset_grant got=%b exp=1", i_arready); end
    @(negedge clk);
    i_arvalid = 0; m_arready = 1;
    @(negedge clk);
    m_arready = 0; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; i_rready = 1;
    #1;
    checks++; if (i_rvalid !== 1'b1 || m_rready !== 1'b1) begin failures++; $display("FAIL mid_reset_in_data got=%b%b exp=11", i_rvalid, m_rready); end
    #1 rst = 0;
    #1;
    checks++; if (i_rvalid !== 1'b0 || i_rdata !== 32'h0 || i_rlast !== 1'b0 || m_rready !== 1'b0) begin failures++; $display("FAIL mid_reset_r_outputs got=%b/%h/%b/%b exp=0", i_rvalid, i_rdata, i_rlast, m_rready); end
    checks++; if (m_arvalid !== 1'b0 || m_araddr !== 32'h0 || m_arid !== 4'h0 || i_arready !== 1'b0) begin failures++; $display("FAIL mid_reset_ar_outputs got=%b/%h/%0d/%b exp=0", m_arvalid, m_araddr, m_arid, i_arready); end
    @(negedge clk);
    m_rvalid = 0; m_rdata = '0; i_rready = 0;
    rst = 1; streak = 0; wr_out = 0; i_req = 0; d_req = 0;
    i_req = 1; i_addr = 32'hBFC0_0400; i_len = 8'd1; i_size = 3'd2;
    grant_and_burst(who);
    checks++; if (who !== 0) begin failures++; $display("FAIL grant_after_reset got=%0d exp=0", who); end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_both_same_cycle();
    test_starvation();
    test_write_order();
    test_b_aw_same_cycle();
    test_random();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
